fetch_decode_buffer: RTL and testbench



---
 rtl/fetch_decode_buffer_pkg.sv | 31 +++
 rtl/fetch_buffer_fifo.sv | 76 +++++++
 rtl/fetch_decode_buffer.sv | 48 ++++
 tb/tb_fetch_decode_buffer.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_decode_buffer_pkg.sv
// Shared types and constants for the fetch-to-decode elastic buffer.
package fetch_decode_buffer_pkg;

    localparam int unsigned FETCH_BUF_DEPTH = 2;
    localparam logic [31:0] NOP_INSTR       = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] Address;
    } fetch_bundle_t;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] PC;
        logic [31:0] PC4;
        logic        misaligned;
    } decode_bundle_t;

    // Turn a fetched instruction into the form decode consumes.
    function automatic decode_bundle_t pack_entry(input fetch_bundle_t fb);
        decode_bundle_t db;
        db.instr      = fb.instr;
        db.PC         = fb.Address;
        db.PC4        = fb.Address + 32'd4;
        db.misaligned = (fb.Address[1:0] != 2'b00);
        return db;
    endfunction

    localparam decode_bundle_t NOP_BUNDLE = '{instr: NOP_INSTR, PC: 32'd0, PC4: 32'd0, misaligned: 1'b0};

endpackage

// File: rtl/fetch_buffer_fifo.sv
// Generic two-entry FIFO: one-bit read/write pointers plus an occupancy count.
module fetch_buffer_fifo #(
    parameter type T = logic [31:0]
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       clr_i,
    input  logic       push_i,
    input  logic       pop_i,
    input  T           wdata_i,
    output T           rdata_o,
    output logic [1:0] count_o
);

    logic [1:0] count_q, count_d;
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    T           entry0_q, entry0_d;
    T           entry1_q, entry1_d;

    // Next-state: clear wins; otherwise the write and read sides advance independently.
    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        entry0_d = entry0_q;
        entry1_d = entry1_q;
        if (clr_i) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push_i) begin
                if (wr_ptr_q) begin
                    entry1_d = wdata_i;
                end else begin
                    entry0_d = wdata_i;
                end
                wr_ptr_d = ~wr_ptr_q;
            end else begin
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_i) begin
                rd_ptr_d = ~rd_ptr_q;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            case ({push_i, pop_i})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            entry0_q <= '0;
            entry1_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            entry0_q <= entry0_d;
            entry1_q <= entry1_d;
        end
    end

    assign rdata_o = rd_ptr_q ? entry1_q : entry0_q;
    assign count_o = count_q;

endmodule

// File: rtl/fetch_decode_buffer.sv
// Elastic fetch->decode stage: bundle packing, flush priority and NOP substitution
// around a two-entry FIFO whose handshakes depend only on registered occupancy.
module fetch_decode_buffer
    import fetch_decode_buffer_pkg::*;
(
    input  logic           clk,
    input  logic           reset,
    input  fetch_bundle_t  FB,
    input  logic           fetch_valid,
    output logic           fetch_ready,
    input  logic           flush,
    input  logic           decode_ready,
    output logic           decode_valid,
    output decode_bundle_t DB,
    output logic [1:0]     count
);

    logic           push_s;
    logic           pop_s;
    decode_bundle_t wdata_s;
    decode_bundle_t head_s;
    logic [1:0]     count_s;

    assign fetch_ready  = (count_s != 2'd2);
    assign decode_valid = (count_s != 2'd0);

    // Flush squashes both the incoming bundle and any pop this cycle.
    assign push_s  = fetch_valid && fetch_ready && !flush;
    assign pop_s   = decode_valid && decode_ready && !flush;
    assign wdata_s = pack_entry(FB);

    fetch_buffer_fifo #(
        .T (decode_bundle_t)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (reset),
        .clr_i   (flush),
        .push_i  (push_s),
        .pop_i   (pop_s),
        .wdata_i (wdata_s),
        .rdata_o (head_s),
        .count_o (count_s)
    );

    assign DB    = decode_valid ? head_s : NOP_BUNDLE;
    assign count = count_s;

endmodule

// File: tb/tb_fetch_decode_buffer.sv
// Directed table-driven bench for fetch_decode_buffer plus reset sequences.
module tb_fetch_decode_buffer;
    import fetch_decode_buffer_pkg::*;

    logic           clk;
    logic           reset;
    fetch_bundle_t  FB;
    logic           fetch_valid;
    logic           fetch_ready;
    logic           flush;
    logic           decode_ready;
    logic           decode_valid;
    decode_bundle_t DB;
    logic [1:0]     count;

    int tests;
    int fails;

    typedef struct {
        logic        fv;
        logic [31:0] addr;
        logic [31:0] instr;
        logic        dr;
        logic        fl;
        logic [1:0]  e_cnt;
        logic        e_dv;
        logic        e_fr;
        logic [31:0] e_pc;
        logic [31:0] e_pc4;
        logic [31:0] e_instr;
        logic        e_mis;
    } vec_t;

    vec_t vecs[$];

    fetch_decode_buffer dut (
        .clk          (clk),
        .reset        (reset),
        .FB           (FB),
        .fetch_valid  (fetch_valid),
        .fetch_ready  (fetch_ready),
        .flush        (flush),
        .decode_ready (decode_ready),
        .decode_valid (decode_valid),
        .DB           (DB),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic fv, input logic [31:0] addr, input logic [31:0] instr,
                       input logic dr, input logic fl, input logic [1:0] e_cnt,
                       input logic e_dv, input logic e_fr, input logic [31:0] e_pc,
                       input logic [31:0] e_pc4, input logic [31:0] e_instr, input logic e_mis);
        vec_t v;
        v.fv = fv; v.addr = addr; v.instr = instr; v.dr = dr; v.fl = fl;
        v.e_cnt = e_cnt; v.e_dv = e_dv; v.e_fr = e_fr; v.e_pc = e_pc;
        v.e_pc4 = e_pc4; v.e_instr = e_instr; v.e_mis = e_mis;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic fv, input logic [31:0] addr, input logic [31:0] instr,
                         input logic dr, input logic fl);
        fetch_valid  = fv;
        FB.Address   = addr;
        FB.instr     = instr;
        decode_ready = dr;
        flush        = fl;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        drive(1'b1, 32'h40, 32'h1234, 1'b0, 1'b0);

        // Streaming, decode always ready: occupancy stays at one.
        add(1'b1, 32'h00, 32'hA, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h00, 32'h04, 32'hA, 1'b0);
        add(1'b1, 32'h04, 32'hB, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h04, 32'h08, 32'hB, 1'b0);
        add(1'b1, 32'h08, 32'hC, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h08, 32'h0C, 32'hC, 1'b0);
        add(1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h00, 32'h00, NOP_INSTR, 1'b0);
        // Back-pressure: fill, third bundle ignored, then drain in order.
        add(1'b1, 32'h10, 32'h10, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h10, 32'h14, 32'h10, 1'b0);
        add(1'b1, 32'h14, 32'h14, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h10, 32'h14, 32'h10, 1'b0);
        add(1'b1, 32'h18, 32'h18, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h10, 32'h14, 32'h10, 1'b0);
        add(1'b1, 32'h18, 32'h18, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h14, 32'h18, 32'h14, 1'b0);
        add(1'b1, 32'h18, 32'h18, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h18, 32'h1C, 32'h18, 1'b0);
        add(1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h00, 32'h00, NOP_INSTR, 1'b0);
        // Flush while full with a pending push and pop.
        add(1'b1, 32'h20, 32'h20, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'h20, 32'h24, 32'h20, 1'b0);
        add(1'b1, 32'h24, 32'h24, 1'b0, 1'b0, 2'd2, 1'b1, 1'b0, 32'h20, 32'h24, 32'h20, 1'b0);
        add(1'b1, 32'h28, 32'h28, 1'b1, 1'b1, 2'd0, 1'b0, 1'b1, 32'h00, 32'h00, NOP_INSTR, 1'b0);
        add(1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h00, 32'h00, NOP_INSTR, 1'b0);
        // PC4 wrap and misaligned pass-through.
        add(1'b1, 32'hFFFF_FFFC, 32'h55, 1'b0, 1'b0, 2'd1, 1'b1, 1'b1, 32'hFFFF_FFFC, 32'h0, 32'h55, 1'b0);
        add(1'b1, 32'h102, 32'h66, 1'b1, 1'b0, 2'd1, 1'b1, 1'b1, 32'h102, 32'h106, 32'h66, 1'b1);
        add(1'b0, 32'h00, 32'h0, 1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'h00, 32'h00, NOP_INSTR, 1'b0);

        // Reset held with fetch_valid asserted.
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset%0d_count", i), {30'd0, count}, 32'd0);
            check($sformatf("reset%0d_dvalid", i), {31'd0, decode_valid}, 32'd0);
            check($sformatf("reset%0d_instr", i), DB.instr, 32'h13);
            check($sformatf("reset%0d_fready", i), {31'd0, fetch_ready}, 32'd1);
        end
        @(negedge clk);
        reset = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            drive(vecs[i].fv, vecs[i].addr, vecs[i].instr, vecs[i].dr, vecs[i].fl);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), {30'd0, count}, {30'd0, vecs[i].e_cnt});
            check($sformatf("v%0d_dvalid", i), {31'd0, decode_valid}, {31'd0, vecs[i].e_dv});
            check($sformatf("v%0d_fready", i), {31'd0, fetch_ready}, {31'd0, vecs[i].e_fr});
            check($sformatf("v%0d_pc", i), DB.PC, vecs[i].e_pc);
            check($sformatf("v%0d_pc4", i), DB.PC4, vecs[i].e_pc4);
            check($sformatf("v%0d_instr", i), DB.instr, vecs[i].e_instr);
            check($sformatf("v%0d_mis", i), {31'd0, DB.misaligned}, {31'd0, vecs[i].e_mis});
        end

        // Async reset mid-stream: fill to two, then drop reset between edges.
        @(negedge clk);
        drive(1'b1, 32'h200, 32'h77, 1'b0, 1'b0);
        @(negedge clk);
        drive(1'b1, 32'h204, 32'h78, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("arst_pre_count", {30'd0, count}, 32'd2);
        #2;
        reset = 1'b0;
        #1;
        check("arst_count", {30'd0, count}, 32'd0);
        check("arst_dvalid", {31'd0, decode_valid}, 32'd0);
        check("arst_fready", {31'd0, fetch_ready}, 32'd1);
        check("arst_instr", DB.instr, 32'h13);
        @(posedge clk);
        #1;
        check("arst_hold_count", {30'd0, count}, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        drive(1'b1, 32'h300, 32'h99, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        check("resume_count", {30'd0, count}, 32'd1);
        check("resume_pc", DB.PC, 32'h300);
        @(negedge clk);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        check("resume_drain_count", {30'd0, count}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
